// File: rtl/arrow_scheduler.sv
// rtl/arrow_scheduler.sv - beat divider and song FSM strobing arrow codes into the arrow buffer
// Optional ARROW_SCHED_LFSR_EN selects an 8-bit LFSR arrow pattern instead of the rotating counter.
module arrow_scheduler #(
  parameter int NUM_ARROWS_BITS = 2,
  parameter int BEAT_DIV        = 12_500_000,
  parameter int SONG_BEATS      = 64,
  parameter int COUNTDOWN_BEATS = 4,
  parameter int PIPE_DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     pause_i,
  input  logic [1:0]               tempo_sel_i,
  output logic                     shift_en_o,
  output logic [NUM_ARROWS_BITS:0] next_arrow_o,
  output logic [7:0]               beat_idx_o,
  output logic                     playing_o,
  output logic                     song_done_o
);
  localparam int AW    = NUM_ARROWS_BITS + 1;
  localparam int DIV_W = $clog2(BEAT_DIV) + 1;
`ifdef ARROW_SCHED_LFSR_EN
  localparam logic [7:0] PAT_SEED = 8'hA5;
`else
  localparam logic [7:0] PAT_SEED = 8'd1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d, period_q, period_d;
  logic [7:0]         cnt_q, cnt_d, beat_idx_q, beat_idx_d, pat_q, pat_d;
  logic               shift_en_q, shift_en_d, done_q, done_d;
  logic [AW-1:0]      arrow_q, arrow_d, pat_arrow;
  logic [7:0]         pat_next;
  logic               active, start_ok, tick;

`ifdef ARROW_SCHED_LFSR_EN
  assign pat_arrow = (pat_q[2:0] <= 3'd4) ? AW'(pat_q[2:0]) : '0;
  assign pat_next  = {pat_q[6:0], pat_q[7] ^ pat_q[5] ^ pat_q[4] ^ pat_q[3]};
`else
  assign pat_arrow = AW'(pat_q[2:0]);
  assign pat_next  = (pat_q == 8'd4) ? 8'd0 : pat_q + 8'd1;
`endif

  assign active   = (state_q == S_COUNTDOWN) || (state_q == S_PLAY) || (state_q == S_DRAIN);
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Pause masks the tick, so a paused divider parked at period-1 fires on resume.
  assign tick     = active && !pause_i && (div_q == period_q - DIV_W'(1));

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    beat_idx_d = beat_idx_q;
    pat_d      = pat_q;
    shift_en_d = 1'b0;
    arrow_d    = '0;

    if (active && !pause_i) div_d = tick ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_COUNTDOWN: if (tick) begin
        shift_en_d = 1'b1;
        if (cnt_q == 8'(COUNTDOWN_BEATS - 1)) begin
          state_d = S_PLAY;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_PLAY: if (tick) begin
        shift_en_d = 1'b1;
        arrow_d    = pat_arrow;
        pat_d      = pat_next;
        beat_idx_d = beat_idx_q + 8'd1;
        if (cnt_q == 8'(SONG_BEATS - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_DRAIN: if (tick) begin
        shift_en_d = 1'b1;
        if (cnt_q == 8'(PIPE_DEPTH - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
      end
      default: ;
    endcase

    if (start_ok) begin
      state_d    = S_COUNTDOWN;
      div_d      = '0;
      period_d   = DIV_W'(BEAT_DIV) >> tempo_sel_i;
      cnt_d      = '0;
      beat_idx_d = '0;
      pat_d      = PAT_SEED;
    end
    // song_done lags entry into DONE by one cycle so it follows the last strobe.
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      period_q   <= DIV_W'(BEAT_DIV);
      cnt_q      <= '0;
      beat_idx_q <= '0;
      pat_q      <= PAT_SEED;
      shift_en_q <= 1'b0;
      arrow_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      beat_idx_q <= beat_idx_d;
      pat_q      <= pat_d;
      shift_en_q <= shift_en_d;
      arrow_q    <= arrow_d;
      done_q     <= done_d;
    end
  end

  assign shift_en_o   = shift_en_q;
  assign next_arrow_o = arrow_q;
  assign beat_idx_o   = beat_idx_q;
  assign playing_o    = active;
  assign song_done_o  = done_q;
endmodule

// File: tb/tb_arrow_scheduler.sv
// tb/tb_arrow_scheduler.sv - bench for arrow_scheduler against a strobe-list song model
// Build with ARROW_SCHED_LFSR_EN defined to select the LFSR arrow model.
module tb_arrow_scheduler;
  localparam int BEAT_DIV = 8;
  localparam int SONG_B   = 6;
  localparam int CD_B     = 2;
  localparam int PIPE_B   = 4;
  localparam int TOTAL    = CD_B + SONG_B + PIPE_B;

  logic       clk = 1'b0;
  logic       rst, start, pause;
  logic [1:0] tempo;
  logic       shift_en, playing, song_done;
  logic [2:0] next_arrow;
  logic [7:0] beat_idx;

  int vectors = 0;
  int miscompares = 0;
  int m_phase, m_cnt, m_period, m_n, strobes_seen;

  arrow_scheduler #(
    .NUM_ARROWS_BITS(2), .BEAT_DIV(BEAT_DIV), .SONG_BEATS(SONG_B),
    .COUNTDOWN_BEATS(CD_B), .PIPE_DEPTH(PIPE_B)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .pause_i(pause), .tempo_sel_i(tempo),
    .shift_en_o(shift_en), .next_arrow_o(next_arrow), .beat_idx_o(beat_idx),
    .playing_o(playing), .song_done_o(song_done)
  );

  always #5 clk = ~clk;

  // Arrow for the k-th song beat (0-based).
  function automatic logic [2:0] pat(input int k);
`ifdef ARROW_SCHED_LFSR_EN
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return (l[2:0] <= 3'd4) ? l[2:0] : 3'd0;
`else
    return 3'((k + 1) % 5);
`endif
  endfunction

  function automatic logic [2:0] arrow_at(input int idx);
    if (idx < CD_B || idx >= CD_B + SONG_B) return 3'd0;
    return pat(idx - CD_B);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic es, input logic [2:0] ea, input int bi,
                               input logic ep, input logic ed);
    check("shift_en", 32'(shift_en), 32'(es));
    check("next_arrow", 32'(next_arrow), 32'(ea));
    check("beat_idx", 32'(beat_idx), 32'(bi));
    check("playing", 32'(playing), 32'(ep));
    check("song_done", 32'(song_done), 32'(ed));
  endtask

  // One clock edge with the given start/pause, then model update and output check.
  task automatic step(input logic st, input logic ps);
    int old_phase, bi;
    logic es;
    logic [2:0] ea;
    start = st;
    pause = ps;
    @(posedge clk);
    #1;
    start = 1'b0;
    old_phase = m_phase;
    es = 1'b0;
    ea = 3'd0;
    if (m_phase == 1) begin
      if (!ps) begin
        m_cnt++;
        if (m_cnt == m_period) begin
          m_cnt = 0;
          es = 1'b1;
          ea = arrow_at(m_n);
          m_n++;
          if (m_n == TOTAL) m_phase = 2;
        end
      end
    end else if (st) begin
      m_phase = 1;
      m_cnt = 0;
      m_period = BEAT_DIV >> tempo;
      m_n = 0;
    end
    bi = (m_n < CD_B) ? 0 : ((m_n > CD_B + SONG_B) ? SONG_B : m_n - CD_B);
    check_outputs(es, ea, bi, m_phase == 1, old_phase == 2 && m_phase == 2);
    if (shift_en) strobes_seen++;
  endtask

  // Run until the model reaches DONE; pause_pct gives random pause density.
  task automatic finish_song(input int pause_pct, input int start_pct);
    int budget;
    budget = 2000;
    while (m_phase == 1 && budget > 0) begin
      step($urandom_range(0, 99) < start_pct, $urandom_range(0, 99) < pause_pct);
      budget--;
    end
    check("song_complete", 32'(m_phase), 32'd2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic run_until_strobes(input int n);
    int budget;
    budget = 500;
    while (m_n < n && m_phase == 1 && budget > 0) begin
      step(1'b0, 1'b0);
      budget--;
    end
    check("reach_beat", 32'(m_n), 32'(n));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; tempo = 2'd0;
    m_phase = 0; m_cnt = 0; m_period = BEAT_DIV; m_n = 0; strobes_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, 3'd0, 0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) step(1'b0, i[3]);
    check("idle_strobes", 32'(strobes_seen), 32'd0);

    strobes_seen = 0;
    tempo = 2'd0;
    step(1'b1, 1'b0);
    finish_song(0, 0);
    check("song1_strobes", 32'(strobes_seen), 32'(TOTAL));

    strobes_seen = 0;
    tempo = 2'd2;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    finish_song(0, 0);
    check("pause_song_strobes", 32'(strobes_seen), 32'(TOTAL));

    strobes_seen = 0;
    tempo = 2'd0;
    step(1'b1, 1'b0);
    run_until_strobes(CD_B + 2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    finish_song(0, 0);
    check("ignored_start_strobes", 32'(strobes_seen), 32'(TOTAL));
    tempo = 2'd1;
    step(1'b1, 1'b0);
    finish_song(10, 0);

    tempo = 2'd1;
    step(1'b1, 1'b0);
    run_until_strobes(CD_B + 3);
    #2 rst = 1'b1;
    #1;
    check_outputs(1'b0, 3'd0, 0, 1'b0, 1'b0);
    m_phase = 0; m_cnt = 0; m_n = 0;
    @(posedge clk);
    #1;
    check_outputs(1'b0, 3'd0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    strobes_seen = 0;
    tempo = 2'd0;
    step(1'b1, 1'b0);
    finish_song(0, 0);
    check("post_reset_strobes", 32'(strobes_seen), 32'(TOTAL));

    for (int s = 0; s < 6; s++) begin
      tempo = 2'($urandom_range(0, 3));
      for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, 1'($urandom_range(0, 1)));
      finish_song(30, 5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
